// File: rtl/wb_host_master.sv
// Wishbone Classic single-transfer master driven by a simple host request port.
// One transfer at a time: IDLE -> BUS (until ack or timeout) -> GAP -> IDLE.
module wb_host_master #(
  parameter int WB_ADDR_WIDTH  = 24,
  parameter int WB_DATA_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,

  input  logic                       host_req_i,
  input  logic                       host_we_i,
  input  logic [WB_ADDR_WIDTH-1:0]   host_adr_i,
  input  logic [WB_DATA_WIDTH-1:0]   host_dat_i,
  input  logic [WB_DATA_WIDTH/8-1:0] host_sel_i,
  output logic                       host_busy_o,
  output logic                       host_done_o,
  output logic                       host_err_o,
  output logic [WB_DATA_WIDTH-1:0]   host_dat_o,

  output logic                       wb_cyc_o,
  output logic                       wb_stb_o,
  output logic                       wb_we_o,
  output logic [WB_ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [WB_DATA_WIDTH-1:0]   wb_dat_o,
  output logic [WB_DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic                       wb_ack_i,
  input  logic [WB_DATA_WIDTH-1:0]   wb_dat_i
);

  localparam int SEL_WIDTH = WB_DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // The counter holds the number of completed ack-less BUS cycles, so the
  // timeout fires on the edge where it reads TIMEOUT_CYCLES-1.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [15:0] timeout_cnt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= ST_IDLE;
      timeout_cnt <= 16'd0;
      host_busy_o <= 1'b0;
      host_done_o <= 1'b0;
      host_err_o  <= 1'b0;
      host_dat_o  <= '0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= {SEL_WIDTH{1'b1}};
    end else begin
      host_done_o <= 1'b0;
      host_err_o  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (host_req_i) begin
            state       <= ST_BUS;
            timeout_cnt <= 16'd0;
            host_busy_o <= 1'b1;
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= 1'b1;
            wb_we_o     <= host_we_i;
            wb_adr_o    <= host_adr_i;
            wb_dat_o    <= host_dat_i;
            wb_sel_o    <= host_sel_i;
          end
        end

        ST_BUS: begin
          // Ack is tested first so it wins over a timeout on the same edge.
          if (wb_ack_i) begin
            state       <= ST_GAP;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            host_done_o <= 1'b1;
            if (!wb_we_o) begin
              host_dat_o <= wb_dat_i;
            end
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            state       <= ST_GAP;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            host_done_o <= 1'b1;
            host_err_o  <= 1'b1;
          end else begin
            timeout_cnt <= timeout_cnt + 16'd1;
          end
        end

        ST_GAP: begin
          state       <= ST_IDLE;
          host_busy_o <= 1'b0;
        end

        default: begin
          state       <= ST_IDLE;
          host_busy_o <= 1'b0;
          wb_cyc_o    <= 1'b0;
          wb_stb_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/wb_host_master.md
WB_HOST_MASTER -- requirements
Module: wb_host_master

Interface
REQ-001 Parameter WB_ADDR_WIDTH, default 24, Wishbone/host address width.
REQ-002 Parameter WB_DATA_WIDTH, default 16, Wishbone/host data width (multiple of 8).
REQ-003 Parameter TIMEOUT_CYCLES, default 255, max cycles wb_cyc_o stays high awaiting ack (range 2..65535).
REQ-004 wb_clk_i  input  1  single clock, all logic on rising edge.
REQ-005 wb_rst_i  input  1  synchronous, active-high reset.
REQ-006 host_req_i  input  1  transaction request, sampled only in IDLE.
REQ-007 host_we_i  input  1  1 = write, 0 = read; captured with host_req_i.
REQ-008 host_adr_i  input  WB_ADDR_WIDTH  address; captured with host_req_i.
REQ-009 host_dat_i  input  WB_DATA_WIDTH  write data; captured with host_req_i.
REQ-010 host_sel_i  input  WB_DATA_WIDTH/8  byte selects; captured with host_req_i.
REQ-011 host_busy_o  output  1  high in every state except IDLE.
REQ-012 host_done_o  output  1  one-cycle completion pulse (ack or timeout).
REQ-013 host_err_o  output  1  one-cycle pulse coincident with host_done_o on timeout only.
REQ-014 host_dat_o  output  WB_DATA_WIDTH  last read data.
REQ-015 wb_cyc_o, wb_stb_o  output  1 each  Wishbone Classic cycle/strobe (always equal).
REQ-016 wb_we_o  output  1;  wb_adr_o  output  WB_ADDR_WIDTH;  wb_dat_o  output  WB_DATA_WIDTH;  wb_sel_o  output  WB_DATA_WIDTH/8.
REQ-017 wb_ack_i  input  1;  wb_dat_i  input  WB_DATA_WIDTH  responder acknowledge and read data.

Function
REQ-018 States SHALL be IDLE, BUS, GAP; all outputs registered.
REQ-019 IDLE with host_req_i=1 at edge E SHALL capture we/adr/dat/sel, enter BUS, and drive wb_cyc_o=wb_stb_o=1 from E onward.
REQ-020 wb_we_o/adr_o/dat_o/sel_o SHALL hold captured values for the whole BUS state; host input changes during BUS are ignored.
REQ-021 host_req_i while busy SHALL be ignored (no queueing).
REQ-022 In BUS, wb_ack_i=1 sampled at edge K SHALL: drop cyc/stb at K, pulse host_done_o for the cycle after K, and for reads load host_dat_o from wb_dat_i sampled at K; writes leave host_dat_o unchanged.
REQ-023 After BUS the block SHALL pass through GAP for exactly one cycle with cyc/stb low, then IDLE; minimum request-to-request spacing is therefore cyc-high cycles + 2.
REQ-024 A 16-bit timeout counter SHALL clear on entry to BUS and increment each BUS cycle without ack.
REQ-025 If cyc/stb has been high for TIMEOUT_CYCLES cycles with no ack, the block SHALL drop cyc/stb, pulse host_done_o and host_err_o together, keep host_dat_o, and enter GAP.
REQ-026 Ack on the same edge the timeout would fire SHALL win: normal completion, host_err_o=0.
REQ-027 wb_ack_i outside BUS SHALL be ignored (no done pulse, no data capture).
REQ-028 host_done_o and host_err_o SHALL never be high for more than one consecutive cycle.

Reset
REQ-029 wb_rst_i=1 at any edge SHALL force IDLE; cyc_o, stb_o, we_o, host_busy_o, host_done_o, host_err_o = 0; wb_adr_o, wb_dat_o, host_dat_o = 0; wb_sel_o = all ones.
REQ-030 Reset during BUS SHALL abort silently: cyc/stb low after that edge, no done/err pulse, counter cleared.
REQ-031 First request SHALL be accepted on the first edge after wb_rst_i deasserts.

Verification
REQ-032 Read: req adr=0x001234, responder acks 5 cycles later with 0xBEEF -> cyc high exactly 5 cycles, one done pulse, host_dat_o=0xBEEF, err=0.
REQ-033 Write: req we=1 adr=0x00ABCD dat=0x5A5A sel=2'b01, ack after 3 cycles -> wb bus shows those values throughout cyc, host_dat_o unchanged, one done pulse.
REQ-034 Timeout: TIMEOUT_CYCLES=8, no ack -> cyc high exactly 8 cycles, done and err pulse together, GAP one cycle, busy low after.
REQ-035 Ack on timeout edge (ack at 8th cycle, TIMEOUT_CYCLES=8) -> done=1, err=0, read data captured.
REQ-036 Back-to-back: host_req_i held high across two transactions -> second cyc begins exactly 2 cycles after first cyc drops; req pulses during BUS produce no extra transaction.
REQ-037 Reset mid-BUS at cycle 2 of 5 -> cyc low next edge, no done pulse, late ack ignored, next request served normally.
